// File: rtl/s7_pkg.sv
// Shared types and the digit-to-segment decoder for the s7 stopwatch.
// Segment patterns are active-low, bit6 = a ... bit0 = g.
package s7_pkg;

   typedef logic [3:0] digit_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] seg_decode(input digit_t d);
      logic [6:0] seg;
      case (d)
         4'd0:    seg = 7'b0000001;
         4'd1:    seg = 7'b1001111;
         4'd2:    seg = 7'b0010010;
         4'd3:    seg = 7'b0000110;
         4'd4:    seg = 7'b1001100;
         4'd5:    seg = 7'b0100100;
         4'd6:    seg = 7'b0100000;
         4'd7:    seg = 7'b0001111;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0000100;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/s7_scan_driver.sv
// Time-multiplexed 7-segment scanner with registered segment/select outputs.
// Optional S7_LEADING_ZERO_BLANK_EN blanks leading zero digits at index >= 3.
module s7_scan_driver
   import s7_pkg::*;
#(
   parameter int unsigned DISPLAYS_NUM = 4,
   parameter int unsigned MLT_CNT      = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [4*DISPLAYS_NUM-1:0]   digits,
   output logic [6:0]                  segments,
   output logic [DISPLAYS_NUM-1:0]     segments_sel
);

   localparam int unsigned CNT_W = (MLT_CNT > 1) ? $clog2(MLT_CNT) : 1;
   localparam int unsigned IDX_W = (DISPLAYS_NUM > 1) ? $clog2(DISPLAYS_NUM) : 1;

   logic [CNT_W-1:0]        scan_cnt;
   logic [IDX_W-1:0]        scan_idx;
   digit_t                  cur_digit;
   logic [DISPLAYS_NUM-1:0] cur_sel;
   logic                    lead_zero;

   always_comb begin
      cur_digit = '0;
      cur_sel   = '1;
      lead_zero = 1'b0;
      for (int unsigned k = 0; k < DISPLAYS_NUM; k++) begin
         if (scan_idx == IDX_W'(k)) begin
            cur_digit  = digits[4*k +: 4];
            cur_sel[k] = 1'b0;
`ifdef S7_LEADING_ZERO_BLANK_EN
            // shifting out the lower digits leaves this digit and all above it
            lead_zero  = (k >= 3) && ((digits >> (4*k)) == '0);
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt     <= '0;
         scan_idx     <= '0;
         segments     <= SEG_BLANK;
         segments_sel <= '1;
      end else begin
         segments     <= lead_zero ? SEG_BLANK : seg_decode(cur_digit);
         segments_sel <= cur_sel;
         if (scan_cnt == CNT_W'(MLT_CNT - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_W'(DISPLAYS_NUM - 1)) ? '0 : scan_idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/s7_stopwatch.sv
// Free-running BCD stopwatch driving multiplexed 7-segment digits.
// Optional macro S7_LEADING_ZERO_BLANK_EN (in s7_scan_driver) blanks leading zeros.
module s7_stopwatch
   import s7_pkg::*;
#(
   parameter int unsigned DISPLAYS_NUM = 4,
   parameter int unsigned CLK_F_HZ     = 1000,
   parameter int unsigned TICK_HZ      = 100,
   parameter int unsigned MLT_CNT      = 10
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   output logic [6:0]              o_segments,
   output logic [DISPLAYS_NUM-1:0] o_segments_sel
);

   localparam int unsigned PRESCALE = ((CLK_F_HZ / TICK_HZ) > 0) ? (CLK_F_HZ / TICK_HZ) : 1;
   localparam int unsigned PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PRE_W-1:0]               prescale_cnt;
   logic                           tick;
   digit_t [DISPLAYS_NUM-1:0]      digits;
   digit_t [DISPLAYS_NUM-1:0]      digits_next;
   logic                           carry;

   assign tick = (prescale_cnt == PRE_W'(PRESCALE - 1));

   // carry ripples through any run of 9s within the same cycle
   always_comb begin
      digits_next = digits;
      carry       = tick;
      for (int unsigned k = 0; k < DISPLAYS_NUM; k++) begin
         if (carry) begin
            if (digits[k] == 4'd9) begin
               digits_next[k] = '0;
            end else begin
               digits_next[k] = digits[k] + 4'd1;
               carry          = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         prescale_cnt <= '0;
         digits       <= '0;
      end else begin
         prescale_cnt <= tick ? '0 : prescale_cnt + 1'b1;
         digits       <= digits_next;
      end
   end

   s7_scan_driver #(
      .DISPLAYS_NUM (DISPLAYS_NUM),
      .MLT_CNT      (MLT_CNT)
   ) u_scan (
      .clk          (i_clk),
      .rst_n        (i_rst),
      .digits       (digits),
      .segments     (o_segments),
      .segments_sel (o_segments_sel)
   );

endmodule

// File: tb/tb_s7_stopwatch.sv
// Self-checking bench for s7_stopwatch: default build plus a prescale-of-1 instance
// that reaches the full-counter rollover quickly. Honours S7_LEADING_ZERO_BLANK_EN.
module tb_s7_stopwatch;

   localparam int unsigned P_A = 10;  // 1000 Hz / 100 Hz
   localparam int unsigned P_B = 1;   // 50 / 100 = 0, clamped to 1

   localparam logic [6:0] SEG_LUT [10] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] seg_a, seg_b;
   logic [3:0] sel_a, sel_b;

   s7_stopwatch #(.DISPLAYS_NUM(4), .CLK_F_HZ(1000), .TICK_HZ(100), .MLT_CNT(10)) dut (
      .i_clk(clk), .i_rst(rst), .o_segments(seg_a), .o_segments_sel(sel_a));

   s7_stopwatch #(.DISPLAYS_NUM(4), .CLK_F_HZ(50), .TICK_HZ(100), .MLT_CNT(10)) dut_fast (
      .i_clk(clk), .i_rst(rst), .o_segments(seg_b), .o_segments_sel(sel_b));

   always #5 clk = ~clk;

   typedef struct packed { logic [3:0] sel; logic [6:0] seg; } disp_t;
   typedef struct { int unsigned n; disp_t a; disp_t b; } exp_t;
   typedef struct { int unsigned n; logic [3:0] sel; logic [6:0] seg; } vec_t;

   exp_t        sb[$];
   vec_t        vt[16];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned edges    = 0;

   // Display expected after n rising edges since reset release (closed form).
   function automatic disp_t model(input int unsigned n, input int unsigned p);
      disp_t       r;
      int unsigned m, c, k, d, div;
      if (n == 0) return '{sel: 4'b1111, seg: 7'b1111111};
      m   = n - 1;
      c   = (m / p) % 10000;
      k   = (m / 10) % 4;
      div = 1;
      for (int unsigned j = 0; j < k; j++) div = div * 10;
      d   = (c / div) % 10;
      r.sel    = 4'b1111;
      r.sel[k] = 1'b0;
      r.seg    = SEG_LUT[d];
`ifdef S7_LEADING_ZERO_BLANK_EN
      if (k == 3 && d == 0) r.seg = 7'b1111111;
`endif
      return r;
   endfunction

   task automatic check(input string name, input disp_t got, input disp_t exp, input int unsigned n);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s edge=%0d got sel=%b seg=%b expected sel=%b seg=%b",
                  name, n, got.sel, got.seg, exp.sel, exp.seg);
      end
   endtask

   task automatic step();
      exp_t        e;
      int unsigned nn;
      nn  = rst ? edges + 1 : 0;
      e.n = nn;
      e.a = model(nn, P_A);
      e.b = model(nn, P_B);
      sb.push_back(e);
      @(posedge clk);
      #1;
      edges = nn;
      e = sb.pop_front();
      check("scan_a", {sel_a, seg_a}, e.a, e.n);
      check("scan_b", {sel_b, seg_b}, e.b, e.n);
   endtask

   // Reset asserted mid-cycle must blank both outputs before any clock edge.
   task automatic async_reset();
      #2 rst = 1'b0;
      #1;
      check("async_rst_a", {sel_a, seg_a}, '{sel: 4'b1111, seg: 7'b1111111}, edges);
      check("async_rst_b", {sel_b, seg_b}, '{sel: 4'b1111, seg: 7'b1111111}, edges);
      edges = 0;
      repeat (3) step();
      rst = 1'b1;
   endtask

   initial begin
      vt[0]  = '{1,     4'b1110, 7'b0000001};
      vt[1]  = '{10,    4'b1110, 7'b0000001};
      vt[2]  = '{11,    4'b1101, 7'b0000001};
`ifdef S7_LEADING_ZERO_BLANK_EN
      vt[3]  = '{31,    4'b0111, 7'b1111111};
`else
      vt[3]  = '{31,    4'b0111, 7'b0000001};
`endif
      vt[4]  = '{41,    4'b1110, 7'b1001100};
      vt[5]  = '{81,    4'b1110, 7'b0000000};
      vt[6]  = '{121,   4'b1110, 7'b0010010};
      vt[7]  = '{131,   4'b1101, 7'b1001111};
      vt[8]  = '{161,   4'b1110, 7'b0100000};
      vt[9]  = '{531,   4'b1101, 7'b0100100};
      vt[10] = '{731,   4'b1101, 7'b0001111};
      vt[11] = '{931,   4'b1101, 7'b0000100};
`ifdef S7_LEADING_ZERO_BLANK_EN
      vt[12] = '{5351,  4'b0111, 7'b1111111};
`else
      vt[12] = '{5351,  4'b0111, 7'b0000001};
`endif
      vt[13] = '{8021,  4'b1011, 7'b0000000};
      vt[14] = '{10031, 4'b0111, 7'b1001111};
      vt[15] = '{15351, 4'b0111, 7'b1001111};

      repeat (5) step();
      rst = 1'b1;

      for (int i = 0; i < 16; i++) begin
         while (edges < vt[i].n) begin
            step();
            if (edges == 10000)
               check("wrap_b_9999", {sel_b, seg_b}, '{sel: 4'b0111, seg: 7'b0000100}, edges);
            if (edges == 10001)
               check("wrap_b_0000", {sel_b, seg_b}, '{sel: 4'b1110, seg: 7'b0000001}, edges);
         end
         check("vec", {sel_a, seg_a}, '{sel: vt[i].sel, seg: vt[i].seg}, edges);
      end
      while (edges < 15500) step();

      async_reset();
      while (edges < 12345) step();
      async_reset();
      repeat (300) step();

      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got=%0d entries expected=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
